// File: rtl/line_serializer.sv
// Serializes one LEN-bit cache line into LEN/BEAT_W burst beats, least-significant beat first.
// Beat 0 is driven the cycle after acceptance; bmem_ready low holds the current beat; done pulses once after the last beat.
module line_serializer #(
    parameter int LEN    = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN-1:0]    line_i,
    input  logic [31:0]       addr_i,
    input  logic              line_valid,
    output logic              line_ready,
    output logic [31:0]       bmem_addr,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    output logic              done
);
    localparam int BEATS = LEN / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LEN / 8);
    localparam logic [31:0]      ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t state;
    state_t state_nxt;

    // Viewing the buffer as an array of beats lets the counter select a slice directly.
    logic [BEATS-1:0][BEAT_W-1:0] line_buf;
    logic [31:0]                  addr_q;
    logic [CNT_W-1:0]             cnt;
    logic                         accept;
    logic                         beat_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        line_ready = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        done       = 1'b0;
        accept     = 1'b0;
        beat_acc   = 1'b0;
        case (state)
            IDLE: begin
                line_ready = 1'b1;
                if (line_valid) begin
                    accept    = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = line_buf[cnt];
                if (bmem_ready) begin
                    beat_acc = 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer and address only load in IDLE, so new requests cannot disturb a burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_buf <= '0;
            addr_q   <= '0;
            cnt      <= '0;
        end else if (accept) begin
            line_buf <= line_i;
            addr_q   <= addr_i & ALIGN_MASK;
            cnt      <= '0;
        end else if (beat_acc) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_line_serializer.sv
// Bench for line_serializer: vector table, directed reset/back-to-back sequences, then random traffic vs a transaction model.
module tb_line_serializer;
    localparam int LEN    = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LEN / BEAT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [LEN-1:0]    line_i;
    logic [31:0]       addr_i;
    logic              line_valid;
    logic              line_ready;
    logic [31:0]       bmem_addr;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic              done;

    line_serializer #(.LEN(LEN), .BEAT_W(BEAT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_i     (line_i),
        .addr_i     (addr_i),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .bmem_addr  (bmem_addr),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit rst;
        bit lv;
        bit rdy;
        int sel;
        bit e_lr;
        bit e_wr;
        bit e_done;
        int e_sel;
        int e_beat;
    } vec_t;

    logic [LEN-1:0] lines [2];
    logic [31:0]    addrs [2];
    logic [31:0]    aligned [2];

    function automatic vec_t mk(bit r, bit lv, bit rdy, int sel, bit lr, bit wr, bit dn, int es, int eb);
        vec_t v;
        v.rst = r; v.lv = lv; v.rdy = rdy; v.sel = sel;
        v.e_lr = lr; v.e_wr = wr; v.e_done = dn; v.e_sel = es; v.e_beat = eb;
        return v;
    endfunction

    function automatic logic [BEAT_W-1:0] beat_of(logic [LEN-1:0] l, int i);
        return l[i*BEAT_W +: BEAT_W];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit e_lr, input bit e_wr,
                           input logic [63:0] e_dat, input logic [31:0] e_addr, input bit e_done);
        chk({tag, ".line_ready"}, 64'(line_ready), 64'(e_lr));
        chk({tag, ".bmem_write"}, 64'(bmem_write), 64'(e_wr));
        chk({tag, ".bmem_wdata"}, 64'(bmem_wdata), e_dat);
        chk({tag, ".bmem_addr"},  64'(bmem_addr),  64'(e_addr));
        chk({tag, ".done"},       64'(done),       64'(e_done));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit lv, input bit rdy, input int sel);
        rst        = r;
        line_valid = lv;
        bmem_ready = rdy;
        line_i     = lines[sel];
        addr_i     = addrs[sel];
    endtask

    // Transaction-level reference: whether a line is held, and how many of its beats memory has taken.
    bit             m_busy;
    int             m_sent;
    logic [LEN-1:0] m_line;
    logic [31:0]    m_addr;

    vec_t vq[$];
    int   beat_cyc[$];
    logic [63:0] beat_dat[$];
    int   done_cyc[$];

    initial begin
        lines[0] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        lines[1] = {64'hDDDD_0004_DDDD_0004, 64'hCCCC_0003_CCCC_0003,
                    64'hBBBB_0002_BBBB_0002, 64'hAAAA_0001_AAAA_0001};
        addrs[0] = 32'h0000_1234;  aligned[0] = 32'h0000_1220;
        addrs[1] = 32'hABCD_EF7F;  aligned[1] = 32'hABCD_EF60;

        // reset, reset priority
        vq.push_back(mk(1,0,0,0, 1,0,0,0,-1));
        vq.push_back(mk(1,1,1,0, 1,0,0,0,-1));
        // basic burst, then idle hold
        vq.push_back(mk(0,1,1,0, 0,1,0,0,0));
        vq.push_back(mk(0,0,1,0, 0,1,0,0,1));
        vq.push_back(mk(0,0,1,0, 0,1,0,0,2));
        vq.push_back(mk(0,0,1,0, 0,1,0,0,3));
        vq.push_back(mk(0,0,1,0, 0,0,1,0,-1));
        vq.push_back(mk(0,0,1,0, 1,0,0,0,-1));
        vq.push_back(mk(0,0,1,0, 1,0,0,0,-1));
        // stall pattern 1,0,0,1,0,1,1
        vq.push_back(mk(0,1,0,0, 0,1,0,0,0));
        vq.push_back(mk(0,0,1,0, 0,1,0,0,1));
        vq.push_back(mk(0,0,0,0, 0,1,0,0,1));
        vq.push_back(mk(0,0,0,0, 0,1,0,0,1));
        vq.push_back(mk(0,0,1,0, 0,1,0,0,2));
        vq.push_back(mk(0,0,0,0, 0,1,0,0,2));
        vq.push_back(mk(0,0,1,0, 0,1,0,0,3));
        vq.push_back(mk(0,0,1,0, 0,0,1,0,-1));
        vq.push_back(mk(0,0,0,0, 1,0,0,0,-1));
        // second line offered during SEND/DONE must be ignored
        vq.push_back(mk(0,1,0,0, 0,1,0,0,0));
        vq.push_back(mk(0,1,0,1, 0,1,0,0,0));
        vq.push_back(mk(0,1,1,1, 0,1,0,0,1));
        vq.push_back(mk(0,1,1,1, 0,1,0,0,2));
        vq.push_back(mk(0,1,1,1, 0,1,0,0,3));
        vq.push_back(mk(0,1,1,1, 0,0,1,0,-1));
        vq.push_back(mk(0,1,1,1, 1,0,0,0,-1));
        vq.push_back(mk(0,1,1,1, 0,1,0,1,0));
        vq.push_back(mk(0,0,1,1, 0,1,0,1,1));
        vq.push_back(mk(0,0,1,1, 0,1,0,1,2));
        vq.push_back(mk(0,0,1,1, 0,1,0,1,3));
        vq.push_back(mk(0,0,1,1, 0,0,1,1,-1));
        vq.push_back(mk(0,0,0,1, 1,0,0,1,-1));

        drive(1, 0, 0, 0);
        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            string tag;
            v = vq[i];
            drive(v.rst, v.lv, v.rdy, v.sel);
            tick();
            tag = $sformatf("vec%0d", i);
            chk_out(tag, v.e_lr, v.e_wr,
                    v.e_wr ? 64'(beat_of(lines[v.e_sel], v.e_beat)) : 64'd0,
                    v.e_wr ? aligned[v.e_sel] : 32'd0, v.e_done);
        end

        // reset after two beats accepted: burst aborts, next line starts at beat 0
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 1, 0); tick();
        chk_out("rstmid.pre", 0, 1, 64'(beat_of(lines[0], 2)), aligned[0], 0);
        drive(1, 1, 1, 1); tick();
        chk_out("rstmid.abort", 1, 0, 64'd0, 32'd0, 0);
        drive(0, 1, 0, 1); tick();
        chk_out("rstmid.new0", 0, 1, 64'(beat_of(lines[1], 0)), aligned[1], 0);
        drive(0, 0, 1, 1); tick();
        chk_out("rstmid.new1", 0, 1, 64'(beat_of(lines[1], 1)), aligned[1], 0);
        drive(0, 0, 1, 1); tick(); tick(); tick();
        chk_out("rstmid.done", 0, 0, 64'd0, 32'd0, 1);
        drive(0, 0, 0, 1); tick();
        chk_out("rstmid.idle", 1, 0, 64'd0, 32'd0, 0);

        // back-to-back with line_valid held high
        for (int c = 0; c < 14; c++) begin
            drive(0, c <= 6, 1, (c == 0) ? 0 : 1);
            tick();
            if (bmem_write) begin
                beat_cyc.push_back(c);
                beat_dat.push_back(64'(bmem_wdata));
            end
            if (done) done_cyc.push_back(c);
        end
        chk("b2b.beat_count", 64'(beat_cyc.size()), 64'd8);
        chk("b2b.done_count", 64'(done_cyc.size()), 64'd2);
        for (int i = 0; i < beat_cyc.size() && i < 8; i++) begin
            chk($sformatf("b2b.beat%0d_cycle", i), 64'(beat_cyc[i]), 64'((i < 4) ? i : i + 2));
            chk($sformatf("b2b.beat%0d_data", i), beat_dat[i], 64'(beat_of(lines[i / 4], i % 4)));
        end
        for (int i = 0; i < done_cyc.size() && i < 2; i++)
            chk($sformatf("b2b.done%0d_cycle", i), 64'(done_cyc[i]), 64'(4 + 6 * i));

        // random traffic against the transaction model
        drive(1, 0, 0, 0); tick();
        m_busy = 0; m_sent = 0; m_line = '0; m_addr = '0;
        for (int c = 0; c < 600; c++) begin
            bit e_wr;
            rst        = ($urandom_range(0, 59) == 0);
            line_valid = ($urandom_range(0, 2) != 0);
            bmem_ready = $urandom_range(0, 1);
            for (int w = 0; w < LEN / 32; w++) line_i[w*32 +: 32] = $urandom;
            addr_i = $urandom;
            if (rst) begin
                m_busy = 0; m_sent = 0;
            end else if (!m_busy) begin
                if (line_valid) begin
                    m_busy = 1; m_sent = 0; m_line = line_i;
                    m_addr = (addr_i / 32'd32) * 32'd32;
                end
            end else if (m_sent == BEATS) begin
                m_busy = 0;
            end else if (bmem_ready) begin
                m_sent++;
            end
            tick();
            e_wr = m_busy && (m_sent < BEATS);
            chk_out($sformatf("rnd%0d", c), !m_busy, e_wr,
                    e_wr ? 64'(m_line[m_sent*BEAT_W +: BEAT_W]) : 64'd0,
                    e_wr ? m_addr : 32'd0, m_busy && (m_sent == BEATS));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
